// File: rtl/fifo_window_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_window_reader_if
//   Bundles the window reader's start strobe, banked-memory read port and
//   output stream into one interface.
//
//   Signals (direction as seen by the reader, i.e. the master modport):
//     loop_offset_en_i  in   1-cycle start strobe
//     loop_offset_i     in   window start offset (AW bits)
//     mem_rd_en_o       out  bank read strobe
//     mem_sel_o         out  bank select
//     mem_addr_o        out  word address inside the bank
//     mem_rd_data_i     in   read data, valid one cycle after mem_rd_en_o
//     win_data_o        out  output sample
//     win_idx_o         out  sample index within the window
//     win_valid_o       out  output valid
//     win_ready_i       in   downstream ready
//     win_last_o        out  last sample of the window
//     busy_o            out  window in progress
//     done_o            out  pulse after the last transfer
//     overrun_o         out  pulse: start strobe while busy
//     offset_err_o      out  pulse: start offset out of range
//
//   master : the window reader itself
//   slave  : the surroundings (loop-offset stage, sample memory, consumer)
// ---------------------------------------------------------------------------
interface fifo_window_reader_if #(
  parameter int DATA_W          = 16,
  parameter int LOG2_MEM_DEPTH  = 8,
  parameter int LOG2_NUM_OF_MEM = 3
);
  localparam int AW = LOG2_MEM_DEPTH + LOG2_NUM_OF_MEM;

  logic                       loop_offset_en_i;
  logic [AW-1:0]              loop_offset_i;
  logic                       mem_rd_en_o;
  logic [LOG2_NUM_OF_MEM-1:0] mem_sel_o;
  logic [LOG2_MEM_DEPTH-1:0]  mem_addr_o;
  logic [DATA_W-1:0]          mem_rd_data_i;
  logic [DATA_W-1:0]          win_data_o;
  logic [AW-1:0]              win_idx_o;
  logic                       win_valid_o;
  logic                       win_ready_i;
  logic                       win_last_o;
  logic                       busy_o;
  logic                       done_o;
  logic                       overrun_o;
  logic                       offset_err_o;

  modport master (
    input  loop_offset_en_i, loop_offset_i, mem_rd_data_i, win_ready_i,
    output mem_rd_en_o, mem_sel_o, mem_addr_o,
    output win_data_o, win_idx_o, win_valid_o, win_last_o,
    output busy_o, done_o, overrun_o, offset_err_o
  );

  modport slave (
    output loop_offset_en_i, loop_offset_i, mem_rd_data_i, win_ready_i,
    input  mem_rd_en_o, mem_sel_o, mem_addr_o,
    input  win_data_o, win_idx_o, win_valid_o, win_last_o,
    input  busy_o, done_o, overrun_o, offset_err_o
  );
endinterface

// File: rtl/fifo_window_reader.sv
// ---------------------------------------------------------------------------
// fifo_window_reader
//   On each start strobe, streams one full ECG window (ECG_WINDOW samples)
//   out of the banked sample memory, starting at the R-peak loop offset and
//   wrapping at ECG_WINDOW, so every window leaves R-peak aligned.
//
//   Ports:
//     clk      in  clock, all logic on posedge
//     reset_n  in  asynchronous active-low reset
//     bus      fifo_window_reader_if.master (strobe, memory port, stream)
//
//   Pipeline: read issued in cycle N, memory data on the bus in N+1, captured
//   into a 2-entry output buffer at the end of N+1, presented from N+2.
// ---------------------------------------------------------------------------
module fifo_window_reader #(
  parameter int DATA_W          = 16,
  parameter int LOG2_MEM_DEPTH  = 8,
  parameter int LOG2_NUM_OF_MEM = 3,
  parameter int ECG_WINDOW      = 800
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fifo_window_reader_if.master bus
);

  localparam int AW    = LOG2_MEM_DEPTH + LOG2_NUM_OF_MEM;
  // Two extra bits so 2*ECG_WINDOW cannot wrap even when ECG_WINDOW == 2**AW.
  localparam int OFF_W = AW + 2;

  localparam logic [AW-1:0]    WIN_LAST = AW'(ECG_WINDOW - 1);
  localparam logic [OFF_W-1:0] WIN_X1   = OFF_W'(ECG_WINDOW);
  localparam logic [OFF_W-1:0] WIN_X2   = OFF_W'(2 * ECG_WINDOW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic              last;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t        r_state;
  logic [AW-1:0] r_ptr;        // next memory word to read, always < ECG_WINDOW
  logic [AW-1:0] r_issue_cnt;  // reads issued in this window
  logic [AW-1:0] r_rx_idx;     // window index of the next captured sample
  logic          r_pending;    // a read was issued last cycle; its data is on the bus now
  logic [1:0]    r_occ;        // output buffer occupancy, 0..2
  entry_t        r_buf [2];    // slot 0 is always the head presented downstream
  logic          r_done;
  logic          r_overrun;
  logic          r_offset_err;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic          w_valid;
  logic          w_pop;
  logic          w_issue;
  logic          w_start;
  logic          w_last_pop;
  logic [AW-1:0] w_ptr_next;
  logic [AW-1:0] w_start_ptr;
  logic          w_off_bad;
  entry_t        w_new;

  assign w_valid    = (r_occ != 2'd0);
  assign w_pop      = w_valid && bus.win_ready_i;
  assign w_last_pop = w_pop && r_buf[0].last;
  assign w_start    = bus.loop_offset_en_i && (r_state == S_IDLE);

  // Issue only if every sample already committed (buffered, or on the bus
  // now) plus this new one still fits in the buffer after this cycle's pop.
  // Counting the pop is what lets a held-high ready sustain 1 sample/cycle.
  assign w_issue = (r_state == S_READ) &&
                   (({1'b0, r_occ} + {2'b00, r_pending}) < (3'd2 + {2'b00, w_pop}));

  assign w_ptr_next = (r_ptr == WIN_LAST) ? '0 : r_ptr + 1'b1;

  assign w_new = '{last: (r_rx_idx == WIN_LAST), idx: r_rx_idx, data: bus.mem_rd_data_i};

  // Fold the loop offset back into [0, ECG_WINDOW): one window of slack is
  // accepted silently, anything further is flagged and starts at 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_start_ptr = '0;
    w_off_bad   = 1'b0;
    if (OFF_W'(bus.loop_offset_i) < WIN_X1) begin
      w_start_ptr = bus.loop_offset_i;
    end else if (OFF_W'(bus.loop_offset_i) < WIN_X2) begin
      w_start_ptr = AW'(OFF_W'(bus.loop_offset_i) - WIN_X1);
    end else begin
      w_off_bad = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM, read pointer and status pulses
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_issue_cnt  <= '0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_offset_err <= 1'b0;
    end else begin
      // A strobe is rejected in any non-idle state, including the cycle of
      // the final transfer; the running window is left untouched.
      r_overrun    <= bus.loop_offset_en_i && (r_state != S_IDLE);
      r_offset_err <= w_start && w_off_bad;
      r_done       <= w_last_pop;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_READ;
            r_ptr       <= w_start_ptr;
            r_issue_cnt <= '0;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_ptr       <= w_ptr_next;
            r_issue_cnt <= r_issue_cnt + 1'b1;
            if (r_issue_cnt == WIN_LAST) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read-data capture and 2-entry output buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_rx_idx  <= '0;
      r_occ     <= 2'd0;
      // NOTE: the buffer entries are reset too; they drive the outputs
      // directly and must read as zero while reset is held.
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
    end else begin
      r_pending <= w_issue;

      if (w_start) begin
        r_rx_idx <= '0;
      end else if (r_pending) begin
        r_rx_idx <= r_rx_idx + 1'b1;
      end

      // The issue rule guarantees a push never meets a full buffer.
      case ({r_pending, w_pop})
        2'b01: begin
          r_buf[0] <= r_buf[1];
          r_occ    <= r_occ - 2'd1;
        end
        2'b10: begin
          if (r_occ == 2'd0) r_buf[0] <= w_new;
          else               r_buf[1] <= w_new;
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf[0] <= w_new;
          end else begin
            r_buf[0] <= r_buf[1];
            r_buf[1] <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.mem_rd_en_o  = w_issue;
  assign bus.mem_sel_o    = r_ptr[AW-1:LOG2_MEM_DEPTH];
  assign bus.mem_addr_o   = r_ptr[LOG2_MEM_DEPTH-1:0];
  assign bus.win_data_o   = r_buf[0].data;
  assign bus.win_idx_o    = r_buf[0].idx;
  assign bus.win_valid_o  = w_valid;
  assign bus.win_last_o   = w_valid && r_buf[0].last;
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.done_o       = r_done;
  assign bus.overrun_o    = r_overrun;
  assign bus.offset_err_o = r_offset_err;

endmodule
